vga_plot_sink: RTL and testbench
================================

Name: vga_plot_sink

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot strobe) driven by the drawing engines (fillscreen, circle, Reuleaux triangle).
- Stores each in-range plotted pixel into an on-chip 160x120x3 framebuffer.
- Provides a whole-screen clear engine and a raster-order scan-out stream, used for display and for testbench readback.

Parameters:
- WIDTH, 160, pixels per row; x valid range 0..WIDTH-1.
- HEIGHT, 120, rows; y valid range 0..HEIGHT-1.

Ports:
- clk  input  1  system clock. All logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- vga_x  input  8  plot x coordinate.
- vga_y  input  7  plot y coordinate.
- vga_colour  input  3  plot colour.
- vga_plot  input  1  write strobe; one pixel per cycle high.
- clear_start  input  1  request fill of the whole framebuffer with clear_colour.
- clear_colour  input  3  fill colour, sampled on the cycle clear_start is accepted.
- scan_start  input  1  request raster scan-out.
- scan_x  output  8  x of the current scan pixel.
- scan_y  output  7  y of the current scan pixel.
- scan_colour  output  3  stored colour at (scan_x, scan_y).
- scan_valid  output  1  scan_x, scan_y and scan_colour are valid this cycle.
- scan_done  output  1  one-cycle pulse after the last scan pixel.
- busy  output  1  high in CLEAR or SCAN.
- drop_count  output  16  saturating count of rejected plots.

Behaviour:
- Reset values: scan_x=0, scan_y=0, scan_colour=0, scan_valid=0, scan_done=0, busy=0, drop_count=0, state=IDLE. Framebuffer contents are not reset.
- Address: addr = y*WIDTH + x, 15 bits. For the defaults this is (y<<7)+(y<<5)+x.
- Memory is dual-port: one synchronous write port, one synchronous read port with 1-cycle read latency.
- States:
  - IDLE: clear_start=1 -> CLEAR; otherwise scan_start=1 -> SCAN. If both are high in the same cycle, CLEAR wins and scan_start is dropped.
  - CLEAR: writes the latched clear_colour to addresses 0..WIDTH*HEIGHT-1, one per cycle (19200 cycles), then returns to IDLE. busy=1 throughout.
  - SCAN: issues read addresses 0..19199 in raster order (x fastest), one per cycle. scan_valid rises 1 cycle after the first address. The 19200 valid beats are contiguous. scan_done pulses the cycle after the last valid beat, with state back in IDLE on that same cycle.
- clear_start or scan_start arriving while busy: ignored. Requests are not queued.
- Plot write rules:
  - A plot is accepted when vga_plot=1, vga_x<WIDTH, vga_y<HEIGHT, and the state is IDLE or SCAN.
  - The write commits on that clock edge.
  - Reads issued on the following cycle or later return the new colour.
  - A read issued on the same cycle as a write to the same address returns the old colour.
- Rejected plots: out-of-range coordinates, or any plot during CLEAR. Each increments drop_count by 1; the count saturates at 16'hFFFF and does not wrap.
- Last-writer-wins for repeated plots to the same address.
- Reset mid-operation: state returns to IDLE immediately and outputs take their reset values. A partially cleared framebuffer keeps whatever was written before reset.
- scan_x and scan_y wrap: x 159 -> 0 with y+1; after (159,119) the scan ends. No beat is emitted for 160 or 120.

Test Plan:
- Clear then scan: clear_start with clear_colour=3'b010, wait for busy=0, then scan_start -> exactly 19200 scan_valid beats, all colour 010, first beat (0,0), last beat (159,119), scan_done 1 cycle after the last beat.
- Plot then scan:
  - Stimulus: clear with colour 0; plot (0,0)=7, (159,0)=5, (0,119)=3, (159,119)=1; then scan.
  - Required: exactly those four pixels are non-zero, and drop_count=0.
- Out-of-range and clear-time plots:
  - Stimulus: plots at (160,5), (5,120), and (255,127); then 3 plots during CLEAR.
  - Required: drop_count=6 and framebuffer unchanged.
- Write during scan: during SCAN, plot (10,0)=6 on the same cycle the scan reads address 10 -> beat shows the old colour. A repeat scan shows 6. A plot to (20,0) issued 5 cycles before its read -> beat shows the new colour.
- Arbitration:
  - Stimulus: clear_start and scan_start high in the same cycle; later, scan_start while in CLEAR.
  - Required: only CLEAR runs, with no scan_valid activity and no scan_done.
- Reset mid-operation: assert rst_n=0 at scan beat 500 -> scan_valid=0, busy=0, scan_done=0 immediately. After release, a new scan_start produces a full 19200-beat scan.

Source files
------------

// File: rtl/vga_plot_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_plot_sink
// Brief    : 160x120x3 plot framebuffer with whole-screen clear and raster
//            scan-out of the stored pixels.
// Revision : 1.0 - initial release
// ============================================================================
module vga_plot_sink #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  vga_x,
    input  logic [6:0]  vga_y,
    input  logic [2:0]  vga_colour,
    input  logic        vga_plot,
    input  logic        clear_start,
    input  logic [2:0]  clear_colour,
    input  logic        scan_start,
    output logic [7:0]  scan_x,
    output logic [6:0]  scan_y,
    output logic [2:0]  scan_colour,
    output logic        scan_valid,
    output logic        scan_done,
    output logic        busy,
    output logic [15:0] drop_count
);
    localparam int          c_DEPTH   = WIDTH * HEIGHT;
    localparam logic [14:0] c_LAST    = 15'(c_DEPTH - 1);
    localparam logic [7:0]  c_XLAST   = 8'(WIDTH - 1);
    localparam logic [7:0]  c_WIDTH8  = 8'(WIDTH);
    localparam logic [6:0]  c_HEIGHT7 = 7'(HEIGHT);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_SCAN  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic        w_start_clear;
    logic        w_start_scan;
    logic [14:0] r_addr;
    logic [7:0]  r_cx;
    logic [6:0]  r_cy;
    logic [2:0]  r_clr_colour;
    logic [2:0]  r_mem [0:c_DEPTH-1];

    logic        w_at_last;
    logic        w_scan_rd;
    logic        w_in_range;
    logic        w_accept;
    logic        w_drop;
    logic        w_we;
    logic [14:0] w_paddr;
    logic [14:0] w_waddr;
    logic [2:0]  w_wdata;

    logic [7:0]  r_sx;
    logic [6:0]  r_sy;
    logic [2:0]  r_rdata;
    logic        r_valid;
    logic        r_last_beat;
    logic        r_done;
    logic [15:0] r_drops;

    assign w_at_last  = (r_addr == c_LAST);
    assign w_scan_rd  = (r_state == c_SCAN);
    assign w_paddr    = 15'(vga_y) * 15'(WIDTH) + 15'(vga_x);
    assign w_in_range = (vga_x < c_WIDTH8) && (vga_y < c_HEIGHT7);
    assign w_accept   = vga_plot && w_in_range && (r_state != c_CLEAR);
    assign w_drop     = vga_plot && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_IDLE;
        else        r_state <= w_next;
    end

    // CLEAR has priority over SCAN; requests seen outside IDLE are discarded.
    always_comb begin
        w_next        = r_state;
        w_start_clear = 1'b0;
        w_start_scan  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (clear_start) begin
                    w_next        = c_CLEAR;
                    w_start_clear = 1'b1;
                end else if (scan_start) begin
                    w_next       = c_SCAN;
                    w_start_scan = 1'b1;
                end
            end
            c_CLEAR, c_SCAN: begin
                if (w_at_last) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_clr_colour <= '0;
        end else if (w_start_clear || w_start_scan) begin
            r_addr <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            if (w_start_clear) r_clr_colour <= clear_colour;
        end else if (r_state != c_IDLE) begin
            r_addr <= r_addr + 15'd1;
            if (r_cx == c_XLAST) begin
                r_cx <= '0;
                r_cy <= r_cy + 7'd1;
            end else begin
                r_cx <= r_cx + 8'd1;
            end
        end
    end

    // Single write port shared by the clear engine and accepted plots.
    always_comb begin
        w_we    = w_accept;
        w_waddr = w_paddr;
        w_wdata = vga_colour;
        if (r_state == c_CLEAR) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = r_clr_colour;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    // Read and coordinates are registered together so the beat is aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sx        <= '0;
            r_sy        <= '0;
            r_rdata     <= '0;
            r_valid     <= 1'b0;
            r_last_beat <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_valid     <= w_scan_rd;
            r_last_beat <= w_scan_rd && w_at_last;
            r_done      <= r_last_beat;
            if (w_scan_rd) begin
                r_sx    <= r_cx;
                r_sy    <= r_cy;
                r_rdata <= r_mem[r_addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          r_drops <= '0;
        else if (w_drop && r_drops != 16'hFFFF) r_drops <= r_drops + 16'd1;
    end

    assign scan_x      = r_sx;
    assign scan_y      = r_sy;
    assign scan_colour = r_rdata;
    assign scan_valid  = r_valid;
    assign scan_done   = r_done;
    assign busy        = (r_state == c_CLEAR) || (r_state == c_SCAN);
    assign drop_count  = r_drops;
endmodule
`default_nettype wire

// File: tb/tb_vga_plot_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_plot_sink
// Brief    : Directed self-checking bench for vga_plot_sink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_plot_sink;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        scan_start;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic [2:0]  scan_colour;
    logic        scan_valid;
    logic        scan_done;
    logic        busy;
    logic [15:0] drop_count;

    int vectors = 0;
    int errs    = 0;
    logic [2:0] exp_fb [0:19199];

    always #5 clk = ~clk;

    vga_plot_sink dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .clear_start  (clear_start),
        .clear_colour (clear_colour),
        .scan_start   (scan_start),
        .scan_x       (scan_x),
        .scan_y       (scan_y),
        .scan_colour  (scan_colour),
        .scan_valid   (scan_valid),
        .scan_done    (scan_done),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            if (errs <= 20) $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
        tick();
        vga_plot   = 1'b0;
    endtask

    // Optional arbitration pulses and in-range plots during the fill.
    task automatic do_clear(input logic [2:0] col, input bit arb, input bit plots);
        int busy_cycles = 0;
        int stray       = 0;
        bit ended       = 0;
        clear_start  = 1'b1;
        clear_colour = col;
        scan_start   = arb;
        tick();
        clear_start  = 1'b0;
        scan_start   = 1'b0;
        clear_colour = ~col;
        for (int c = 0; c < 19300 && !ended; c++) begin
            vga_plot   = 1'b0;
            scan_start = 1'b0;
            if (arb && c == 1000) scan_start = 1'b1;
            if (plots && c >= 2000 && c <= 2002) begin
                vga_x      = 8'(c - 2000);
                vga_y      = 7'd1;
                vga_colour = 3'd7;
                vga_plot   = 1'b1;
            end
            if (scan_valid || scan_done) stray++;
            if (busy) busy_cycles++;
            else      ended = 1;
            tick();
        end
        vga_plot   = 1'b0;
        scan_start = 1'b0;
        check("clear_busy_cycles", busy_cycles, 19200);
        check("clear_no_scan_activity", stray, 0);
        tick();
        check("clear_no_queued_request", {busy, scan_valid, scan_done}, 0);
        for (int i = 0; i < 19200; i++) exp_fb[i] = col;
    endtask

    // inject: same-cycle plot at addr 10 and early plot at addr 20.
    task automatic do_scan(input bit inject, input int reset_beat);
        int beats   = 0;
        int done_n  = 0;
        int first_c = -1;
        int last_c  = -1;
        int done_c  = -1;
        bit stop    = 0;
        logic [2:0] expc;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check("scan_busy_start", busy, 1);
        for (int c = 0; c < 19300 && !stop; c++) begin
            vga_plot = 1'b0;
            if (inject && c == 10) begin
                vga_x = 8'd10; vga_y = 7'd0; vga_colour = 3'd6; vga_plot = 1'b1;
            end
            if (inject && c == 15) begin
                vga_x = 8'd20; vga_y = 7'd0; vga_colour = 3'd4; vga_plot = 1'b1;
                exp_fb[20] = 3'd4;
            end
            if (scan_done) begin
                done_n++;
                done_c = c;
                stop   = 1;
            end
            if (scan_valid) begin
                expc = (inject && beats == 10) ? 3'd0 : exp_fb[beats];
                vectors++;
                assert ({scan_x, scan_y, scan_colour} === {8'(beats % 160), 7'(beats / 160), expc}) else begin
                    errs++;
                    if (errs <= 20)
                        $error("FAIL scan_beat_%0d: observed x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                               beats, scan_x, scan_y, scan_colour, beats % 160, beats / 160, expc);
                end
                if (first_c < 0) first_c = c;
                last_c = c;
                if (beats == reset_beat) begin
                    rst_n = 1'b0;
                    #1;
                    check("rst_scan_valid", scan_valid, 0);
                    check("rst_busy", busy, 0);
                    check("rst_scan_done", scan_done, 0);
                    check("rst_scan_xy", {scan_x, scan_y}, 0);
                    stop = 1;
                end
                beats++;
            end
            tick();
        end
        vga_plot = 1'b0;
        if (inject) exp_fb[10] = 3'd6;
        if (reset_beat >= 0) begin
            tick();
            rst_n = 1'b1;
            tick();
            check("post_rst_drop_count", drop_count, 0);
        end else begin
            check("scan_first_beat_latency", first_c, 1);
            check("scan_beat_count", beats, 19200);
            check("scan_done_count", done_n, 1);
            check("scan_done_after_last", done_c, last_c + 1);
            check("scan_idle_at_done", busy, 0);
            tick();
            check("scan_done_one_cycle", {scan_done, scan_valid}, 0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        vga_x        = '0;
        vga_y        = '0;
        vga_colour   = '0;
        vga_plot     = 1'b0;
        clear_start  = 1'b0;
        clear_colour = '0;
        scan_start   = 1'b0;
        tick(); tick(); tick();
        check("reset_scan_x", scan_x, 0);
        check("reset_scan_y", scan_y, 0);
        check("reset_scan_colour", scan_colour, 0);
        check("reset_scan_valid", scan_valid, 0);
        check("reset_scan_done", scan_done, 0);
        check("reset_busy", busy, 0);
        check("reset_drop_count", drop_count, 0);
        rst_n = 1'b1;
        tick();

        // Fill with 010; three plots into already-cleared rows must be dropped.
        do_clear(3'b010, 1'b0, 1'b1);
        check("drop_clear_time", drop_count, 3);
        do_scan(1'b0, -1);

        // Simultaneous clear/scan request, plus a scan request mid-clear.
        do_clear(3'b000, 1'b1, 1'b0);
        check("drop_after_arb", drop_count, 3);

        plot(0, 0, 7);
        plot(159, 0, 5);
        plot(0, 119, 3);
        plot(159, 119, 1);
        exp_fb[0]     = 3'd7;
        exp_fb[159]   = 3'd5;
        exp_fb[19040] = 3'd3;
        exp_fb[19199] = 3'd1;
        check("drop_valid_plots", drop_count, 3);

        plot(160, 5, 7);
        plot(5, 120, 7);
        plot(255, 127, 7);
        check("drop_out_of_range", drop_count, 6);

        do_scan(1'b1, 500);
        do_scan(1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
`default_nettype wire
